// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in one bit per accepted clock, flags every
// occurrence (overlapping included) of PATTERN and keeps a saturating count.
module serial_pattern_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             filled
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  // Fill count at which the history holds a full pattern's worth of bits.
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
  // Fill count at which the bit being accepted completes a full window.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic                 cnt_sat_q, cnt_sat_d;
  logic                 filled_q, filled_d;
  logic [PATTERN_W-1:0] shift_hist_s;
  logic                 hit_s;

  // Next-state logic: clear wipes everything, an accepted bit shifts and
  // compares, an idle cycle holds state and drops the match pulse.
  always_comb begin
    hist_d       = hist_q;
    fill_d       = fill_q;
    match_d      = 1'b0;
    match_cnt_d  = match_cnt_q;
    cnt_sat_d    = cnt_sat_q;
    shift_hist_s = {hist_q[PATTERN_W-2:0], in_bit};
    hit_s        = 1'b0;

    if (clear) begin
      hist_d      = '0;
      fill_d      = '0;
      match_d     = 1'b0;
      match_cnt_d = '0;
      cnt_sat_d   = 1'b0;
    end else if (in_valid) begin
      hist_d = shift_hist_s;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end else begin
        fill_d = fill_q;
      end
      // The fill guard keeps reset zeros in the history from ever
      // completing a pattern.
      hit_s   = (fill_q >= FILL_ARM) && (shift_hist_s == PATTERN);
      match_d = hit_s;
      if (hit_s) begin
        if (match_cnt_q != CNT_MAX) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
        end else begin
          cnt_sat_d = 1'b1;
        end
      end else begin
        match_cnt_d = match_cnt_q;
      end
    end else begin
      match_d = 1'b0;
    end

    filled_d = (fill_d == FILL_MAX);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      cnt_sat_q   <= 1'b0;
      filled_q    <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
      filled_q    <= filled_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign cnt_sat   = cnt_sat_q;
  assign filled    = filled_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: three instances share one
// stimulus stream (default, PATTERN=0011, CNT_W=2); each scenario starts from
// reset and checks the instance it targets.
module tb_serial_pattern_detector;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic in_bit;

  logic       a_match, a_sat, a_filled;
  logic [7:0] a_cnt;
  logic       b_match, b_sat, b_filled;
  logic [7:0] b_cnt;
  logic       c_match, c_sat, c_filled;
  logic [1:0] c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  serial_pattern_detector dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(a_match), .match_cnt(a_cnt), .cnt_sat(a_sat), .filled(a_filled)
  );

  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b0011), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(b_match), .match_cnt(b_cnt), .cnt_sat(b_sat), .filled(b_filled)
  );

  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(c_match), .match_cnt(c_cnt), .cnt_sat(c_sat), .filled(c_filled)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present inputs for one edge, then settle past the edge for sampling.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Stimulus and checks.
  initial begin
    bit s1 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit m1 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int c1 [7] = '{0, 0, 0, 1, 1, 1, 2};
    bit f1 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit s5 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int exp_n;
    bit b;

    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;

    // Reset state.
    do_reset();
    check("rst_match", a_match, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_sat", a_sat, 0);
    check("rst_filled", a_filled, 0);

    // 1011011 back to back: two overlapping matches.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s1[i]);
      check($sformatf("t1_match[%0d]", i), a_match, m1[i]);
      check($sformatf("t1_cnt[%0d]", i), a_cnt, c1[i]);
      check($sformatf("t1_filled[%0d]", i), a_filled, f1[i]);
    end
    step(1'b0, 1'b0);
    check("t1_match_drop", a_match, 0);
    check("t1_cnt_final", a_cnt, 2);

    // Same stream with 0..3 idle cycles after each bit.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s1[i]);
      check($sformatf("t2_match[%0d]", i), a_match, m1[i]);
      check($sformatf("t2_cnt[%0d]", i), a_cnt, c1[i]);
      for (int g = 0; g < (i % 4); g++) begin
        step(1'b0, 1'b1);
        check($sformatf("t2_gap_match[%0d.%0d]", i, g), a_match, 0);
        check($sformatf("t2_gap_cnt[%0d.%0d]", i, g), a_cnt, c1[i]);
      end
    end
    check("t2_cnt_final", a_cnt, 2);

    // PATTERN=0011: reset zeros plus 1,1 must not match.
    do_reset();
    step(1'b1, 1'b1);
    check("t3_guard0", b_match, 0);
    step(1'b1, 1'b1);
    check("t3_guard1", b_match, 0);
    check("t3_guard_cnt", b_cnt, 0);
    step(1'b1, 1'b0);
    check("t3_m0", b_match, 0);
    step(1'b1, 1'b0);
    check("t3_m1", b_match, 0);
    step(1'b1, 1'b1);
    check("t3_m2", b_match, 0);
    step(1'b1, 1'b1);
    check("t3_m3", b_match, 1);
    check("t3_cnt", b_cnt, 1);
    step(1'b0, 1'b0);
    check("t3_drop", b_match, 0);

    // Clear with a valid bit mid-pattern discards everything.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    check("t4_clr_match", a_match, 0);
    check("t4_clr_filled", a_filled, 0);
    check("t4_clr_cnt", a_cnt, 0);
    step(1'b1, 1'b1);
    check("t4_match", a_match, 0);
    check("t4_filled", a_filled, 0);
    check("t4_cnt", a_cnt, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("t4_filled3", a_filled, 0);
    step(1'b1, 1'b1);
    check("t4_post_match", a_match, 1);
    check("t4_post_filled", a_filled, 1);
    check("t4_post_cnt", a_cnt, 1);

    // Reset mid-stream (with a valid bit and clear present) wins.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    clear = 1'b1;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    clear = 1'b0;
    check("t5_rst_match", a_match, 0);
    check("t5_rst_cnt", a_cnt, 0);
    check("t5_rst_sat", a_sat, 0);
    check("t5_rst_filled", a_filled, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s5[i]);
      check($sformatf("t5_match[%0d]", i), a_match, (i == 4) ? 1 : 0);
    end
    check("t5_cnt", a_cnt, 1);

    // CNT_W=2: five overlapping matches saturate the counter.
    do_reset();
    exp_n = 0;
    for (int j = 0; j < 16; j++) begin
      b = (j == 0) ? 1'b1 : (((j - 1) % 3) != 0);
      step(1'b1, b);
      if (j > 0 && (j % 3) == 0) begin
        exp_n++;
      end
      check($sformatf("t6_match[%0d]", j), c_match, (j > 0 && (j % 3) == 0) ? 1 : 0);
      check($sformatf("t6_cnt[%0d]", j), c_cnt, (exp_n > 3) ? 3 : exp_n);
      check($sformatf("t6_sat[%0d]", j), c_sat, (exp_n >= 4) ? 1 : 0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("t6_sat_hold", c_sat, 1);
    check("t6_cnt_hold", c_cnt, 3);
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
    check("t6_clr_sat", c_sat, 0);
    check("t6_clr_cnt", c_cnt, 0);
    check("t6_clr_filled", c_filled, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
